// File: rtl/ibex_mult_pext_seq.sv
// Sequential packed-SIMD multiplier: four 17x9 signed partial products computed
// NumMul per cycle, assembled into 16- or 32-bit lanes, optional per-lane MAC.
module ibex_mult_pext_seq #(
    parameter int NumMul = 2,
    parameter bit SatEn  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic        width16_i,
    input  logic        signed_i,
    input  logic        crossed_i,
    input  logic        mac_i,
    input  logic        sat_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [63:0] acc_i,
    output logic        ready_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] result_o,
    output logic        sat_o
);

    if (NumMul != 1 && NumMul != 2 && NumMul != 4) begin : g_bad_nummul
        $error("ibex_mult_pext_seq: NumMul must be 1, 2 or 4");
    end

    localparam int Cycles = 4 / NumMul;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        vld_p2;
    logic        sat_p2;
    logic [63:0] result_p2;

    logic [31:0] op_a_p0;
    logic [31:0] op_b_p0;
    logic [63:0] acc_p0;
    logic        w16_p0;
    logic        sgn_p0;
    logic        crs_p0;
    logic        mac_p0;
    logic        sat_en_p0;

    logic signed [25:0] pp_p1  [4];
    logic signed [25:0] pp_now [4];

    logic        accept;
    logic        last_mul;
    logic [63:0] prod;
    logic [63:0] acc_res;
    logic        acc_ovf;
    logic        sat_eff;

    // A operand for partial product idx: halfword (16-bit mode) or byte, 17-bit extended.
    function automatic logic signed [16:0] sel_a(input logic [1:0] idx, input logic [31:0] a,
                                                 input logic w16, input logic sgn);
        logic [15:0] h;
        logic [7:0]  by;
        if (w16) begin
            h = idx[1] ? a[31:16] : a[15:0];
            sel_a = {h[15] & sgn, h};
        end else begin
            by = a[{idx, 3'b000} +: 8];
            sel_a = {{9{by[7] & sgn}}, by};
        end
    endfunction

    // B operand: low byte of a halfword is always unsigned, high bytes follow signed_i.
    function automatic logic signed [8:0] sel_b(input logic [1:0] idx, input logic [31:0] b,
                                                input logic w16, input logic sgn,
                                                input logic crs);
        logic [15:0] h;
        logic [7:0]  by;
        logic [1:0]  bi;
        if (w16) begin
            h = (idx[1] ^ crs) ? b[31:16] : b[15:0];
            sel_b = idx[0] ? {h[15] & sgn, h[15:8]} : {1'b0, h[7:0]};
        end else begin
            bi = idx ^ {1'b0, crs};
            by = b[{bi, 3'b000} +: 8];
            sel_b = {by[7] & sgn, by};
        end
    endfunction

    // Returns {clamped, sum}; wraps when sat is low.
    function automatic logic [32:0] add_sat32(input logic [31:0] p, input logic [31:0] c,
                                              input logic sgn, input logic sat);
        logic        [32:0] us;
        logic signed [32:0] ss;
        us = {1'b0, p} + {1'b0, c};
        ss = $signed({p[31], p}) + $signed({c[31], c});
        if (sat && sgn && (ss[32] != ss[31])) begin
            add_sat32 = {1'b1, (ss[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        end else if (sat && !sgn && us[32]) begin
            add_sat32 = {1'b1, 32'hFFFF_FFFF};
        end else begin
            add_sat32 = {1'b0, (sgn ? ss[31:0] : us[31:0])};
        end
    endfunction

    function automatic logic [16:0] add_sat16(input logic [15:0] p, input logic [15:0] c,
                                              input logic sgn, input logic sat);
        logic        [16:0] us;
        logic signed [16:0] ss;
        us = {1'b0, p} + {1'b0, c};
        ss = $signed({p[15], p}) + $signed({c[15], c});
        if (sat && sgn && (ss[16] != ss[15])) begin
            add_sat16 = {1'b1, (ss[16] ? 16'h8000 : 16'h7FFF)};
        end else if (sat && !sgn && us[16]) begin
            add_sat16 = {1'b1, 16'hFFFF};
        end else begin
            add_sat16 = {1'b0, (sgn ? ss[15:0] : us[15:0])};
        end
    endfunction

    assign ready_o  = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept   = start_i && !kill_i && ready_o;
    assign last_mul = (state_q == MUL) && (cnt_q == 2'(Cycles - 1));
    assign sat_eff  = sat_en_p0 & SatEn;

    // Stage p0 -> p1: multiplier slots, slot s handles partial product cnt*NumMul+s
    logic        [1:0]  slot_idx [NumMul];
    logic signed [16:0] slot_a   [NumMul];
    logic signed [8:0]  slot_b   [NumMul];
    logic signed [25:0] slot_p   [NumMul];

    for (genvar s = 0; s < NumMul; s++) begin : g_slot
        assign slot_idx[s] = 2'(32'(cnt_q) * 32'(NumMul) + 32'(s));
        assign slot_a[s]   = sel_a(slot_idx[s], op_a_p0, w16_p0, sgn_p0);
        assign slot_b[s]   = sel_b(slot_idx[s], op_b_p0, w16_p0, sgn_p0, crs_p0);
        assign slot_p[s]   = 26'(slot_a[s]) * 26'(slot_b[s]);
    end

    always_comb begin
        pp_now = pp_p1;
        for (int s = 0; s < NumMul; s++) begin
            pp_now[slot_idx[s]] = slot_p[s];
        end
    end

    // Stage p1 -> p2: lane assembly, high byte product weighted by 2^8
    logic signed [31:0] lane16 [2];
    assign lane16[0] = 32'(pp_now[0]) + (32'(pp_now[1]) <<< 8);
    assign lane16[1] = 32'(pp_now[2]) + (32'(pp_now[3]) <<< 8);
    assign prod = w16_p0 ? {lane16[1], lane16[0]}
                         : {pp_now[3][15:0], pp_now[2][15:0], pp_now[1][15:0], pp_now[0][15:0]};

    // Accumulate stage operates on the product already parked in result_p2
    logic [32:0] s32 [2];
    logic [16:0] s16 [4];

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            s32[l] = add_sat32(result_p2[32*l +: 32], acc_p0[32*l +: 32], sgn_p0, sat_eff);
        end
        for (int k = 0; k < 4; k++) begin
            s16[k] = add_sat16(result_p2[16*k +: 16], acc_p0[16*k +: 16], sgn_p0, sat_eff);
        end
        if (w16_p0) begin
            acc_res = {s32[1][31:0], s32[0][31:0]};
            acc_ovf = s32[1][32] | s32[0][32];
        end else begin
            acc_res = {s16[3][15:0], s16[2][15:0], s16[1][15:0], s16[0][15:0]};
            acc_ovf = s16[3][16] | s16[2][16] | s16[1][16] | s16[0][16];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_a_p0   <= op_a_i;
            op_b_p0   <= op_b_i;
            acc_p0    <= acc_i;
            w16_p0    <= width16_i;
            sgn_p0    <= signed_i;
            crs_p0    <= crossed_i;
            mac_p0    <= mac_i;
            sat_en_p0 <= sat_i;
        end
        if (state_q == MUL) begin
            pp_p1 <= pp_now;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            vld_p2    <= 1'b0;
            sat_p2    <= 1'b0;
            result_p2 <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= MUL;
                        cnt_q   <= 2'd0;
                        sat_p2  <= 1'b0;
                    end
                end
                MUL: begin
                    if (kill_i) begin
                        state_q   <= IDLE;
                        cnt_q     <= 2'd0;
                        result_p2 <= 64'd0;
                        sat_p2    <= 1'b0;
                    end else if (last_mul) begin
                        cnt_q     <= 2'd0;
                        result_p2 <= prod;
                        if (mac_p0) begin
                            state_q <= ACC;
                        end else begin
                            state_q <= DONE;
                            vld_p2  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ACC: begin
                    if (kill_i) begin
                        state_q   <= IDLE;
                        result_p2 <= 64'd0;
                        sat_p2    <= 1'b0;
                    end else begin
                        state_q   <= DONE;
                        result_p2 <= acc_res;
                        sat_p2    <= acc_ovf;
                        vld_p2    <= 1'b1;
                    end
                end
                DONE: begin
                    if (kill_i) begin
                        state_q   <= IDLE;
                        vld_p2    <= 1'b0;
                        result_p2 <= 64'd0;
                        sat_p2    <= 1'b0;
                    end else if (ready_i) begin
                        vld_p2 <= 1'b0;
                        if (accept) begin
                            state_q <= MUL;
                            cnt_q   <= 2'd0;
                            sat_p2  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign valid_o  = vld_p2;
    assign result_o = result_p2;
    assign sat_o    = sat_p2 & SatEn;

endmodule

// File: tb/tb_ibex_mult_pext_seq.sv
// Directed bench for ibex_mult_pext_seq: NumMul=1/2/4 instances share operand
// inputs and each has its own start strobe and result outputs.
module tb_ibex_mult_pext_seq;

    typedef struct {
        logic        w16;
        logic        sgn;
        logic        crs;
        logic        mac;
        logic        sat;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] acc;
        logic [63:0] res;
        logic        exp_sat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        kill;
    logic        w16, sgn, crs, mac, sat_in;
    logic [31:0] op_a, op_b;
    logic [63:0] acc;
    logic        ready_in;
    logic        start_r [3];
    logic        ready_w [3];
    logic        valid_w [3];
    logic [63:0] res_w   [3];
    logic        sat_w   [3];

    int   n_tests;
    int   n_fail;
    vec_t vecs [12];

    always #5 clk = ~clk;

    ibex_mult_pext_seq #(.NumMul(1), .SatEn(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[0]), .kill_i(kill),
        .width16_i(w16), .signed_i(sgn), .crossed_i(crs), .mac_i(mac), .sat_i(sat_in),
        .op_a_i(op_a), .op_b_i(op_b), .acc_i(acc), .ready_o(ready_w[0]),
        .valid_o(valid_w[0]), .ready_i(ready_in), .result_o(res_w[0]), .sat_o(sat_w[0])
    );

    ibex_mult_pext_seq #(.NumMul(2), .SatEn(1'b1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[1]), .kill_i(kill),
        .width16_i(w16), .signed_i(sgn), .crossed_i(crs), .mac_i(mac), .sat_i(sat_in),
        .op_a_i(op_a), .op_b_i(op_b), .acc_i(acc), .ready_o(ready_w[1]),
        .valid_o(valid_w[1]), .ready_i(ready_in), .result_o(res_w[1]), .sat_o(sat_w[1])
    );

    ibex_mult_pext_seq #(.NumMul(4), .SatEn(1'b1)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_r[2]), .kill_i(kill),
        .width16_i(w16), .signed_i(sgn), .crossed_i(crs), .mac_i(mac), .sat_i(sat_in),
        .op_a_i(op_a), .op_b_i(op_b), .acc_i(acc), .ready_o(ready_w[2]),
        .valid_o(valid_w[2]), .ready_i(ready_in), .result_o(res_w[2]), .sat_o(sat_w[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        w16 = v.w16; sgn = v.sgn; crs = v.crs; mac = v.mac; sat_in = v.sat;
        op_a = v.a; op_b = v.b; acc = v.acc;
    endtask

    // Captured operands must make later input changes irrelevant.
    task automatic scramble();
        op_a = $urandom(); op_b = $urandom(); acc = {$urandom(), $urandom()};
        w16 = 1'($urandom_range(0, 1)); sgn = 1'($urandom_range(0, 1));
        crs = 1'($urandom_range(0, 1)); mac = 1'($urandom_range(0, 1));
        sat_in = 1'($urandom_range(0, 1));
    endtask

    // Called on the negedge after the accepting edge (lat0 edges already elapsed).
    task automatic wait_result(input int d, input vec_t v, input string name, input int lat0);
        int lat;
        int exp_lat;
        lat = lat0;
        exp_lat = ((d == 0) ? 4 : (d == 1) ? 2 : 1) + (v.mac ? 1 : 0);
        while (!valid_w[d] && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, res_w[d], v.res);
        check({name, " sat"}, 64'(sat_w[d]), 64'(v.exp_sat));
    endtask

    task automatic run_op(input int d, input vec_t v, input string name);
        @(negedge clk);
        drive_vec(v);
        start_r[d] = 1'b1;
        @(negedge clk);
        start_r[d] = 1'b0;
        scramble();
        wait_result(d, v, name, 0);
    endtask

    task automatic no_valid(input int d, input int n, input string name);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (valid_w[d]) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic check_idle_outputs(input int d, input string name);
        check({name, " valid"}, 64'(valid_w[d]), 64'd0);
        check({name, " result"}, res_w[d], 64'd0);
        check({name, " sat"}, 64'(sat_w[d]), 64'd0);
        check({name, " ready"}, 64'(ready_w[d]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        kill = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
        w16 = 1'b0; sgn = 1'b0; crs = 1'b0; mac = 1'b0; sat_in = 1'b0;
        op_a = '0; op_b = '0; acc = '0;

        //          w16   sgn   crs   mac   sat   A             B             acc                    result                 sat_o
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF0003, 32'h0002FFFE, 64'h0,                 64'hFFFFFFFE_FFFFFFFA, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04030201, 32'h08070605, 64'h0,                 64'h001C0018_000A0006, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000100, 32'h00000100, 64'h00000005_7FFFFFF0, 64'h00000005_7FFFFFFF, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000100, 32'h00000100, 64'h00000005_7FFFFFF0, 64'h00000005_8000FFF0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0,                 64'hFFFE0001_FFFE0001, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h807FFF02, 32'h80020304, 64'h0,                 64'h400000FE_FFFD0008, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00020003, 32'h00050007, 64'h0,                 64'h0000000E_0000000F, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h000000FF, 32'h000000FF, 64'h0003000200010200, 64'h000300020001FFFF, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000080, 32'h0000007F, 64'h0000000000008000, 64'h0000000000008000, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000FFFF, 32'h00000001, 64'h0000000A_00000001, 64'h0000000A_00000000, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h12345678_0001FFFF, 64'h12345678_00000000, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF0003, 32'h0002FFFE, 64'hDEADBEEF_CAFEF00D, 64'hFFFFFFFE_FFFFFFFA, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs(1, "reset");
        no_valid(1, 3, "reset quiet");

        for (int i = 0; i < 12; i++) run_op(1, vecs[i], $sformatf("vec%0d", i));

        run_op(0, vecs[1], "n1 cross8");
        run_op(2, vecs[1], "n4 cross8");
        run_op(0, vecs[2], "n1 macsat");
        run_op(2, vecs[2], "n4 macsat");

        // Stall in DONE, then back-to-back accept on the releasing cycle
        @(negedge clk);
        ready_in = 1'b0;
        drive_vec(vecs[0]);
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        scramble();
        wait_result(1, vecs[0], "hold", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d result", i), res_w[1], vecs[0].res);
            check($sformatf("hold%0d valid", i), 64'(valid_w[1]), 64'd1);
        end
        ready_in = 1'b1;
        drive_vec(vecs[5]);
        start_r[1] = 1'b1;
        #1;
        check("b2b ready", 64'(ready_w[1]), 64'd1);
        @(negedge clk);
        start_r[1] = 1'b0;
        scramble();
        wait_result(1, vecs[5], "b2b", 0);

        // start while busy is ignored
        @(negedge clk);
        drive_vec(vecs[6]);
        start_r[1] = 1'b1;
        @(negedge clk);
        drive_vec(vecs[4]);
        @(negedge clk);
        start_r[1] = 1'b0;
        scramble();
        wait_result(1, vecs[6], "busy start", 1);

        // asynchronous reset mid-operation
        @(negedge clk);
        drive_vec(vecs[2]);
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "midop reset");
        @(negedge clk);
        rst_n = 1'b1;
        no_valid(1, 6, "post reset quiet");

        // kill in the first MUL cycle
        run_op(1, vecs[0], "pre kill");
        @(negedge clk);
        drive_vec(vecs[4]);
        start_r[1] = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_idle_outputs(1, "kill mul");
        no_valid(1, 5, "kill mul quiet");

        // kill and start together in IDLE: kill wins
        @(negedge clk);
        drive_vec(vecs[0]);
        start_r[1] = 1'b1;
        kill = 1'b1;
        @(negedge clk);
        start_r[1] = 1'b0;
        kill = 1'b0;
        no_valid(1, 5, "kill idle quiet");

        // kill in DONE wins over a simultaneous back-to-back start
        run_op(1, vecs[6], "pre kill done");
        kill = 1'b1;
        start_r[1] = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        start_r[1] = 1'b0;
        check("kill done valid", 64'(valid_w[1]), 64'd0);
        no_valid(1, 5, "kill done quiet");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_mult_pext_seq.md
IBEX_MULT_PEXT_SEQ -- requirements
Module: ibex_mult_pext_seq

Interface
REQ-001 SHALL have parameter NumMul, default 2: number of 17x9 signed multiplier slots instantiated; legal values 1, 2, 4; other values SHALL fail elaboration.
REQ-002 SHALL have parameter SatEn, default 1: when 0, saturation logic is removed, sat_o ties to 0 and sat_i is ignored.
REQ-003 clk_i  input  1  clock; the block uses one clock, rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request a new operation; accepted only when ready_o=1.
REQ-006 kill_i  input  1  abort the operation in flight.
REQ-007 width16_i  input  1  1: two 16x16 lanes; 0: four 8x8 lanes.
REQ-008 signed_i  input  1  operands signed (1) or unsigned (0).
REQ-009 crossed_i  input  1  swap B lanes pairwise (halfwords in 16-bit mode; byte k uses B byte k^1 in 8-bit mode).
REQ-010 mac_i  input  1  add products to acc_i per lane.
REQ-011 sat_i  input  1  saturate per lane in MAC mode.
REQ-012 op_a_i, op_b_i  input  32 each  operands.
REQ-013 acc_i  input  64  accumulator operand (16-bit lanes in 8-bit mode, 32-bit lanes in 16-bit mode).
REQ-014 ready_o  output  1  block can accept start_i.
REQ-015 valid_o  output  1  result_o and sat_o are valid.
REQ-016 ready_i  input  1  consumer accepts the result.
REQ-017 result_o  output  64  lane results; lane k at bits [k*LW+LW-1 : k*LW], LW=16 or 32.
REQ-018 sat_o  output  1  at least one lane saturated.

Function
REQ-019 SHALL implement the states IDLE, MUL, ACC and DONE.
REQ-020 IDLE: ready_o=1; start_i=1 and kill_i=0 SHALL capture all operand and mode inputs and enter MUL; later input changes SHALL have no effect.
REQ-021 Work is four partial products PP0..PP3; MUL SHALL compute NumMul of them per cycle, in index order, over 4/NumMul cycles.
REQ-022 16-bit partial products: PP0=A.h0*B.hx[7:0] (zero-extended byte); PP1=A.h0*B.hx[15:8] (sign-extended when signed); PP2, PP3 likewise for A.h1 and B.hy; hx=0, hy=1, swapped when crossed.
REQ-023 16-bit lane product SHALL be PPlo + (PPhi<<8), truncated to 32 bits.
REQ-024 8-bit mode: PPk = A.byte k * B.byte (k, or k^1 when crossed), each 16 bits.
REQ-025 A operand SHALL extend with bit[MSB]&signed_i; B high bytes likewise.
REQ-026 After the last MUL cycle: mac=1 -> ACC (one cycle); otherwise -> DONE.
REQ-027 ACC: lane sum = product + acc lane; with sat_i=1, sum SHALL clamp to [-2^(LW-1), 2^(LW-1)-1] when signed, [0, 2^LW-1] when unsigned; sat_o=1 if any lane clamps; sat_i=0 wraps modulo 2^LW.
REQ-028 DONE: valid_o=1, with result_o and sat_o held stable until ready_i=1; then -> IDLE.
REQ-029 Latency from start acceptance to valid_o SHALL be 4/NumMul cycles, or 4/NumMul+1 cycles with mac_i.
REQ-030 DONE with ready_i=1 SHALL assert ready_o; a simultaneous start_i SHALL be accepted (back-to-back) and valid_o SHALL drop on the next cycle.
REQ-031 kill_i in MUL, ACC or DONE SHALL return to IDLE on the next edge, with no valid_o; kill_i wins over start_i in the same cycle.
REQ-032 start_i while busy (MUL/ACC) SHALL be ignored.
REQ-033 sat_o SHALL be 0 when mac_i=0.

Reset
REQ-034 rst_ni=0 SHALL force IDLE asynchronously, including mid-operation, and set valid_o=0, result_o=0, sat_o=0 and ready_o=1 (ready_o=0 while rst_ni is low is also allowed).
REQ-035 After reset release, no valid_o SHALL occur without a new start_i.

Verification (NumMul=2 unless stated)
REQ-036 Signed 16-bit, A=0xFFFF0003, B=0x0002FFFE -> valid_o 2 cycles after start, result_o=0xFFFFFFFE_FFFFFFFA, sat_o=0.
REQ-037 Unsigned 8-bit crossed, A=0x04030201, B=0x08070605 -> result_o=0x001C0018000A0006; repeat with NumMul=1 (4 cycles) and NumMul=4 (1 cycle).
REQ-038 Signed 16-bit MAC with saturation, A=0x00000100, B=0x00000100, acc_i=0x00000005_7FFFFFF0 -> 3 cycles, result_o=0x00000005_7FFFFFFF, sat_o=1; the same with sat_i=0 -> 0x00000005_8000FFF0, sat_o=0.
REQ-039 Hold ready_i=0 for 3 cycles in DONE -> result_o stable; then ready_i=1 with start_i=1 -> second op accepted, its result correct.
REQ-040 Assert kill_i in the first MUL cycle, and separately rst_ni=0 mid-op -> IDLE, valid_o never asserted, outputs as in REQ-034.
